circuito_exp4_top: RTL and testbench

//  Memory-sequence game top level (Genius-like) for the FPGA board. Player repeats a fixed
//  16-entry one-hot sequence on 4 switches; the block compares each play with ROM contents.
//  It ends in a win after 16 correct plays or in a loss on the first wrong play.

---
 rtl/circuito_exp4_top.sv | 193 +++++++++++++++++++
 tb/tb_circuito_exp4_top.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/circuito_exp4_top.sv
// Memory-sequence game (Genius-like): the player repeats a fixed 16-entry one-hot
// sequence on four switches; each play is compared against ROM until a win or a loss.
module circuito_exp4_top (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    output logic       acertou,
    output logic       errou,
    output logic       pronto,
    output logic [3:0] leds,
    output logic       db_igual,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_estado,
    output logic [6:0] db_jogadafeita,
    output logic       db_clock,
    output logic       db_iniciar,
    output logic       db_tem_jogada
);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTOU = 4'hA,
        FIM_ERROU   = 4'hE
    } estado_t;

    function automatic logic [3:0] rom_dado(input logic [3:0] endereco);
        logic [3:0] dado;
        case (endereco)
            4'h0:    dado = 4'h1;
            4'h1:    dado = 4'h2;
            4'h2:    dado = 4'h4;
            4'h3:    dado = 4'h8;
            4'h4:    dado = 4'h4;
            4'h5:    dado = 4'h2;
            4'h6:    dado = 4'h1;
            4'h7:    dado = 4'h1;
            4'h8:    dado = 4'h2;
            4'h9:    dado = 4'h2;
            4'hA:    dado = 4'h4;
            4'hB:    dado = 4'h4;
            4'hC:    dado = 4'h8;
            4'hD:    dado = 4'h8;
            4'hE:    dado = 4'h1;
            4'hF:    dado = 4'h4;
            default: dado = 4'h0;
        endcase
        return dado;
    endfunction

    // Active-low segments, bit order gfedcba.
    function automatic logic [6:0] hex7seg(input logic [3:0] valor);
        logic [6:0] seg;
        case (valor)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    estado_t    state_q, state_d;
    logic [3:0] contador_q, contador_d;
    logic [3:0] jogada_q, jogada_d;
    logic       tem_jogada_q, tem_jogada_d;
    logic       acertou_q, acertou_d;
    logic       errou_q, errou_d;
    logic       pronto_q, pronto_d;

    logic       tem_jogada_s;
    logic       jogada_pulso_s;
    logic       igual_s;
    logic       zera_s;
    logic       registra_s;
    logic       conta_s;
    logic       fim_s;

    assign tem_jogada_s   = |chaves;
    assign jogada_pulso_s = tem_jogada_s & ~tem_jogada_q;
    assign igual_s        = (jogada_q == rom_dado(contador_q));
    assign fim_s          = (contador_q == 4'hF);

    // Control FSM: next state and datapath commands.
    always_comb begin
        state_d    = state_q;
        zera_s     = 1'b0;
        registra_s = 1'b0;
        conta_s    = 1'b0;
        case (state_q)
            INICIAL: begin
                if (iniciar) state_d = PREPARACAO;
                else         state_d = INICIAL;
            end
            PREPARACAO: begin
                zera_s  = 1'b1;
                state_d = ESPERA;
            end
            ESPERA: begin
                if (jogada_pulso_s) state_d = REGISTRA;
                else                state_d = ESPERA;
            end
            REGISTRA: begin
                registra_s = 1'b1;
                state_d    = COMPARA;
            end
            COMPARA: begin
                if (!igual_s)   state_d = FIM_ERROU;
                else if (fim_s) state_d = FIM_ACERTOU;
                else            state_d = PROXIMO;
            end
            PROXIMO: begin
                conta_s = 1'b1;
                state_d = ESPERA;
            end
            FIM_ACERTOU, FIM_ERROU: begin
                if (iniciar) state_d = PREPARACAO;
                else         state_d = state_q;
            end
            default: state_d = INICIAL;
        endcase
    end

    // Datapath next values; flags are decoded from the next state so they register in step with it.
    always_comb begin
        contador_d   = contador_q;
        jogada_d     = jogada_q;
        tem_jogada_d = tem_jogada_s;
        if (zera_s)       contador_d = 4'h0;
        else if (conta_s) contador_d = contador_q + 4'd1;
        else              contador_d = contador_q;
        if (zera_s)          jogada_d = 4'h0;
        else if (registra_s) jogada_d = chaves;
        else                 jogada_d = jogada_q;
        acertou_d = (state_d == FIM_ACERTOU);
        errou_d   = (state_d == FIM_ERROU);
        pronto_d  = (state_d == FIM_ACERTOU) || (state_d == FIM_ERROU);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= INICIAL;
            contador_q   <= 4'h0;
            jogada_q     <= 4'h0;
            tem_jogada_q <= 1'b0;
            acertou_q    <= 1'b0;
            errou_q      <= 1'b0;
            pronto_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            contador_q   <= contador_d;
            jogada_q     <= jogada_d;
            tem_jogada_q <= tem_jogada_d;
            acertou_q    <= acertou_d;
            errou_q      <= errou_d;
            pronto_q     <= pronto_d;
        end
    end

    assign acertou        = acertou_q;
    assign errou          = errou_q;
    assign pronto         = pronto_q;
    assign leds           = jogada_q;
    assign db_igual       = igual_s;
    assign db_contagem    = hex7seg(contador_q);
    assign db_memoria     = hex7seg(rom_dado(contador_q));
    assign db_estado      = hex7seg(state_q);
    assign db_jogadafeita = hex7seg(jogada_q);
    assign db_clock       = clock;
    assign db_iniciar     = iniciar;
    assign db_tem_jogada  = tem_jogada_s;

endmodule

// File: tb/tb_circuito_exp4_top.sv
// Directed bench for the memory-sequence game: start, loss, restart, win, multi-bit play, mid-game reset.
module tb_circuito_exp4_top;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic [3:0] chaves;
    logic       acertou, errou, pronto;
    logic [3:0] leds;
    logic       db_igual;
    logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita;
    logic       db_clock, db_iniciar, db_tem_jogada;

    int n_checks;
    int n_fails;

    logic [3:0] seq [16];
    logic [6:0] seg [16];

    circuito_exp4_top dut (
        .clock          (clock),
        .reset          (reset),
        .iniciar        (iniciar),
        .chaves         (chaves),
        .acertou        (acertou),
        .errou          (errou),
        .pronto         (pronto),
        .leds           (leds),
        .db_igual       (db_igual),
        .db_contagem    (db_contagem),
        .db_memoria     (db_memoria),
        .db_estado      (db_estado),
        .db_jogadafeita (db_jogadafeita),
        .db_clock       (db_clock),
        .db_iniciar     (db_iniciar),
        .db_tem_jogada  (db_tem_jogada)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fails = n_fails + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic play(input logic [3:0] v);
        chaves = v;
        step(10);
        chaves = 4'h0;
        step(5);
    endtask

    task automatic restart();
        iniciar = 1'b1;
        step(1);
        iniciar = 1'b0;
        step(2);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};
        seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        reset   = 1'b1;
        iniciar = 1'b0;
        chaves  = 4'h0;
        step(3);
        reset = 1'b0;
        step(10);
        check("reset_estado", db_estado, 7'h40);
        check("reset_pronto", pronto, 1'b0);
        check("reset_acertou", acertou, 1'b0);
        check("reset_errou", errou, 1'b0);
        check("reset_leds", leds, 4'h0);
        check("reset_contagem", db_contagem, 7'h40);
        check("reset_memoria", db_memoria, 7'h79);

        // Start with iniciar held for 5 clocks, then three correct plays.
        iniciar = 1'b1;
        step(5);
        iniciar = 1'b0;
        check("start_estado", db_estado, 7'h24);
        check("start_db_iniciar", db_iniciar, 1'b0);
        chaves = 4'h4;
        #1;
        check("tem_jogada_comb", db_tem_jogada, 1'b1);
        chaves = 4'h0;
        #1;
        check("tem_jogada_zero", db_tem_jogada, 1'b0);
        play(4'h1);
        check("play1_leds", leds, 4'h1);
        play(4'h2);
        play(4'h4);
        check("p3_contagem", db_contagem, 7'h30);
        check("p3_estado", db_estado, 7'h24);
        check("p3_pronto", pronto, 1'b0);
        check("p3_leds", leds, 4'h4);
        check("p3_memoria", db_memoria, 7'h00);
        check("p3_igual", db_igual, 1'b0);

        // Wrong 4th play; walk the registra/compara latency cycle by cycle.
        chaves = 4'h1;
        step(1);
        check("lat_registra", db_estado, 7'h19);
        step(1);
        check("lat_compara", db_estado, 7'h12);
        check("lat_leds", leds, 4'h1);
        step(1);
        check("lat_fim_errou", db_estado, 7'h06);
        check("err_errou", errou, 1'b1);
        check("err_pronto", pronto, 1'b1);
        check("err_acertou", acertou, 1'b0);
        check("err_jogadafeita", db_jogadafeita, 7'h79);
        chaves = 4'h0;
        step(3);
        play(4'h8);
        check("err_ignores_play", db_estado, 7'h06);
        check("err_hold_leds", leds, 4'h1);

        // Restart from the loss state.
        restart();
        check("rs_estado", db_estado, 7'h24);
        check("rs_contagem", db_contagem, 7'h40);
        check("rs_leds", leds, 4'h0);
        check("rs_errou", errou, 1'b0);
        check("rs_pronto", pronto, 1'b0);

        // Full winning sequence.
        for (int i = 0; i < 16; i++) begin
            play(seq[i]);
            if (i < 15) check("win_contagem", db_contagem, seg[i + 1]);
        end
        check("win_acertou", acertou, 1'b1);
        check("win_pronto", pronto, 1'b1);
        check("win_errou", errou, 1'b0);
        check("win_estado", db_estado, 7'h08);
        check("win_contagem_final", db_contagem, 7'h0E);
        check("win_leds", leds, 4'h4);
        check("win_igual", db_igual, 1'b1);

        // Multi-bit play is registered as-is and compares unequal.
        restart();
        play(4'h3);
        check("multi_errou", errou, 1'b1);
        check("multi_leds", leds, 4'h3);
        check("multi_estado", db_estado, 7'h06);

        // Reset mid-game, with iniciar asserted to show reset priority.
        restart();
        play(4'h1);
        play(4'h2);
        check("mid_contagem", db_contagem, 7'h24);
        reset   = 1'b1;
        iniciar = 1'b1;
        step(5);
        check("mid_reset_estado", db_estado, 7'h40);
        check("mid_db_iniciar", db_iniciar, 1'b1);
        reset   = 1'b0;
        iniciar = 1'b0;
        step(1);
        check("mid_estado", db_estado, 7'h40);
        check("mid_contagem_zero", db_contagem, 7'h40);
        check("mid_leds", leds, 4'h0);
        check("mid_flags", {acertou, errou, pronto}, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
